// File: rtl/fetch_seq_ctrl_if.sv
// Handshake/control bundle between the fetch sequencer and the IFU/datapath.
// The slave modport is the controller side; the master modport is the datapath side.
interface fetch_seq_ctrl_if;
  logic        run;
  logic [31:0] instr;
  logic        alu_zero;
  logic        mem_ready;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  npc_sel;
  logic        reg_we;
  logic [1:0]  reg_dst;
  logic [1:0]  wd_sel;
  logic        alu_src;
  logic [1:0]  ext_op;
  logic [1:0]  alu_op;
  logic        dm_re;
  logic        dm_we;
  logic [2:0]  state;
  logic [31:0] retired;
  logic        illegal;
  logic        bus_err;

  modport slave (
    input  run, instr, alu_zero, mem_ready,
    output ir_we, pc_we, npc_sel, reg_we, reg_dst, wd_sel, alu_src, ext_op,
           alu_op, dm_re, dm_we, state, retired, illegal, bus_err
  );

  modport master (
    output run, instr, alu_zero, mem_ready,
    input  ir_we, pc_we, npc_sel, reg_we, reg_dst, wd_sel, alu_src, ext_op,
           alu_op, dm_re, dm_we, state, retired, illegal, bus_err
  );
endinterface

// File: rtl/fetch_seq_ctrl.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, IFU PC
// strobes, datapath controls, data-memory wait timeout and retirement count.
module fetch_seq_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            reset,
  fetch_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_t      r_state, w_next;
  logic [5:0]  r_op, r_fn;
  logic [7:0]  r_wait;
  logic [31:0] r_retired;
  logic        r_illegal, r_bus_err;

  logic w_rtype, w_addu, w_subu, w_jr, w_ori, w_lw, w_sw, w_beq, w_lui, w_j, w_jal;
  logic w_legal;
  logic [1:0] w_cls_op, w_cls_ext;
  logic       w_cls_src;

  logic       w_ir_we, w_pc_we, w_reg_we, w_alu_src, w_dm_re, w_dm_we;
  logic [1:0] w_npc_sel, w_reg_dst, w_wd_sel, w_ext_op, w_alu_op;
  logic       w_wait_clr, w_wait_inc, w_set_ill, w_set_berr;

  // Only opcode and funct steer control, so only those fields are latched.
  assign w_rtype = (r_op == 6'h00);
  assign w_addu  = w_rtype && (r_fn == 6'h21);
  assign w_subu  = w_rtype && (r_fn == 6'h23);
  assign w_jr    = w_rtype && (r_fn == 6'h08);
  assign w_ori   = (r_op == 6'h0D);
  assign w_lw    = (r_op == 6'h23);
  assign w_sw    = (r_op == 6'h2B);
  assign w_beq   = (r_op == 6'h04);
  assign w_lui   = (r_op == 6'h0F);
  assign w_j     = (r_op == 6'h02);
  assign w_jal   = (r_op == 6'h03);
  assign w_legal = w_addu | w_subu | w_jr | w_ori | w_lw | w_sw | w_beq |
                   w_lui | w_j | w_jal;

  always_comb begin
    w_cls_op  = 2'd0;
    w_cls_src = 1'b0;
    w_cls_ext = 2'd0;
    if (w_subu || w_beq) w_cls_op = 2'd1;
    else if (w_ori || w_lui) w_cls_op = 2'd2;
    if (w_ori || w_lui || w_lw || w_sw) w_cls_src = 1'b1;
    if (w_lui) w_cls_ext = 2'd2;
    else if (w_lw || w_sw) w_cls_ext = 2'd1;
  end

  always_comb begin
    w_next     = r_state;
    w_ir_we    = 1'b0;
    w_pc_we    = 1'b0;
    w_npc_sel  = 2'd0;
    w_reg_we   = 1'b0;
    w_reg_dst  = 2'd0;
    w_wd_sel   = 2'd0;
    w_alu_src  = 1'b0;
    w_ext_op   = 2'd0;
    w_alu_op   = 2'd0;
    w_dm_re    = 1'b0;
    w_dm_we    = 1'b0;
    w_wait_clr = 1'b0;
    w_wait_inc = 1'b0;
    w_set_ill  = 1'b0;
    w_set_berr = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (bus.run) begin
          w_ir_we = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_j || w_jal) begin
          w_pc_we   = 1'b1;
          w_npc_sel = 2'd2;
          w_next    = S_FETCH;
          if (w_jal) begin
            w_reg_we  = 1'b1;
            w_reg_dst = 2'd2;
            w_wd_sel  = 2'd2;
          end
        end else if (w_jr) begin
          w_pc_we   = 1'b1;
          w_npc_sel = 2'd3;
          w_next    = S_FETCH;
        end else if (!w_legal) begin
          w_set_ill = 1'b1;
          w_pc_we   = 1'b1;
          w_next    = S_FETCH;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_alu_op  = w_cls_op;
        w_alu_src = w_cls_src;
        w_ext_op  = w_cls_ext;
        if (w_beq) begin
          w_pc_we   = 1'b1;
          w_npc_sel = bus.alu_zero ? 2'd1 : 2'd0;
          w_next    = S_FETCH;
        end else if (w_lw || w_sw) begin
          w_wait_clr = 1'b1;
          w_next     = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        w_alu_op  = w_cls_op;
        w_alu_src = w_cls_src;
        w_ext_op  = w_cls_ext;
        w_dm_re   = w_lw;
        w_dm_we   = w_sw;
        // A ready on the final allowed cycle completes normally rather than aborting.
        if (bus.mem_ready) begin
          if (w_lw) begin
            w_next = S_WB;
          end else begin
            w_pc_we = 1'b1;
            w_next  = S_FETCH;
          end
        end else if (r_wait == WAIT_LAST) begin
          w_set_berr = 1'b1;
          w_pc_we    = 1'b1;
          w_next     = S_FETCH;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      S_WB: begin
        w_reg_we  = 1'b1;
        w_pc_we   = 1'b1;
        w_reg_dst = {1'b0, w_addu | w_subu};
        w_wd_sel  = {1'b0, w_lw};
        if (!w_lw) begin
          w_alu_op  = w_cls_op;
          w_alu_src = w_cls_src;
          w_ext_op  = w_cls_ext;
        end
        w_next = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_op      <= '0;
      r_fn      <= '0;
      r_wait    <= '0;
      r_retired <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_ir_we) begin
        r_op <= bus.instr[31:26];
        r_fn <= bus.instr[5:0];
      end
      if (w_wait_clr)      r_wait <= '0;
      else if (w_wait_inc) r_wait <= r_wait + 8'd1;
      if (w_pc_we)    r_retired <= r_retired + 32'd1;
      if (w_set_ill)  r_illegal <= 1'b1;
      if (w_set_berr) r_bus_err <= 1'b1;
    end
  end

  // Outputs are forced low combinationally while reset is held.
  assign bus.ir_we   = reset & w_ir_we;
  assign bus.pc_we   = reset & w_pc_we;
  assign bus.npc_sel = reset ? w_npc_sel : '0;
  assign bus.reg_we  = reset & w_reg_we;
  assign bus.reg_dst = reset ? w_reg_dst : '0;
  assign bus.wd_sel  = reset ? w_wd_sel : '0;
  assign bus.alu_src = reset & w_alu_src;
  assign bus.ext_op  = reset ? w_ext_op : '0;
  assign bus.alu_op  = reset ? w_alu_op : '0;
  assign bus.dm_re   = reset & w_dm_re;
  assign bus.dm_we   = reset & w_dm_we;
  assign bus.state   = reset ? r_state : '0;
  assign bus.retired = reset ? r_retired : '0;
  assign bus.illegal = reset & r_illegal;
  assign bus.bus_err = reset & r_bus_err;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl: per-cycle state and control checks for
// each instruction class, memory wait/timeout handling and sticky flags.
module tb_fetch_seq_ctrl;
  logic clk;
  logic reset;
  fetch_seq_ctrl_if bus();

  fetch_seq_ctrl #(.MEM_WAIT_MAX(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] SF = 3'd0, SD = 3'd1, SE = 3'd2, SM = 3'd3, SW = 3'd4;
  localparam logic [31:0] ADDU = 32'h00851021, BEQ = 32'h10000002, LW = 32'h8c030004;
  localparam logic [31:0] SW_I = 32'hac030004, JAL = 32'h0c000d00, JR = 32'h03e00008;
  localparam logic [31:0] BAD = 32'hfc000000;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_ret = 32'd0;
  logic [15:0] ctl;

  assign ctl = {bus.ir_we, bus.pc_we, bus.npc_sel, bus.reg_we, bus.reg_dst, bus.wd_sel,
                bus.alu_src, bus.ext_op, bus.alu_op, bus.dm_re, bus.dm_we};

  // Expected control word, fields in the same order as ctl.
  function automatic logic [15:0] ce(input int irw, input int pcw, input int npc,
                                     input int rw, input int rd, input int wd,
                                     input int src, input int ext, input int op,
                                     input int re, input int we);
    return {1'(irw), 1'(pcw), 2'(npc), 1'(rw), 2'(rd), 2'(wd),
            1'(src), 2'(ext), 2'(op), 1'(re), 1'(we)};
  endfunction

  task automatic step(input int r, input logic [31:0] ins, input int z, input int rdy);
    @(negedge clk);
    bus.run       = 1'(r);
    bus.instr     = ins;
    bus.alu_zero  = 1'(z);
    bus.mem_ready = 1'(rdy);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.run = 1'b1; bus.instr = ADDU; bus.alu_zero = 1'b0; bus.mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (bus.state !== SF) begin bad++; $display("FAIL rst_state got=%0d want=%0d", bus.state, SF); end
    total++; if (ctl !== 16'h0) begin bad++; $display("FAIL rst_ctl got=%h want=%h", ctl, 16'h0); end
    total++; if ({bus.retired, bus.illegal, bus.bus_err} !== 34'd0) begin
      bad++; $display("FAIL rst_regs got=%h/%b/%b want=0", bus.retired, bus.illegal, bus.bus_err); end
    @(negedge clk); reset = 1'b1; bus.run = 1'b0;
    step(1, ADDU, 0, 0); step(0, ADDU, 0, 0); step(0, ADDU, 0, 0); step(0, ADDU, 0, 0);
    total++; if (ctl !== ce(0,1,0,1,1,0,0,0,0,0,0)) begin
      bad++; $display("FAIL rst_pre_wb got=%h want=%h", ctl, ce(0,1,0,1,1,0,0,0,0,0,0)); end
    reset = 1'b0;
    #1;
    total++; if (ctl !== 16'h0) begin bad++; $display("FAIL rst_midwb_ctl got=%h want=0000", ctl); end
    total++; if (bus.state !== SF) begin bad++; $display("FAIL rst_midwb_state got=%0d want=0", bus.state); end
    @(negedge clk); reset = 1'b1; bus.run = 1'b1;
    #1;
    total++; if (ctl !== ce(1,0,0,0,0,0,0,0,0,0,0)) begin
      bad++; $display("FAIL rst_release_irwe got=%h want=%h", ctl, ce(1,0,0,0,0,0,0,0,0,0,0)); end
    total++; if (bus.retired !== 32'd0) begin bad++; $display("FAIL rst_release_ret got=%0d want=0", bus.retired); end
    bus.run = 1'b0;
    exp_ret = 32'd0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) begin
      step(0, ADDU, 0, 0);
      total++; if (bus.state !== SF || ctl !== 16'h0) begin
        bad++; $display("FAIL idle cyc=%0d got=%0d/%h want=0/0000", i, bus.state, ctl); end
    end
    total++; if (bus.retired !== exp_ret) begin bad++; $display("FAIL idle_ret got=%0d want=%0d", bus.retired, exp_ret); end
  endtask

  task automatic test_addu();
    logic [2:0]  es [4];
    logic [15:0] ec [4];
    es = '{SF, SD, SE, SW};
    ec = '{ce(1,0,0,0,0,0,0,0,0,0,0), 16'h0, 16'h0, ce(0,1,0,1,1,0,0,0,0,0,0)};
    for (int i = 0; i < 4; i++) begin
      step(i == 0 ? 1 : 0, ADDU, 0, 0);
      total++; if (bus.state !== es[i]) begin bad++; $display("FAIL addu_state cyc=%0d got=%0d want=%0d", i, bus.state, es[i]); end
      total++; if (ctl !== ec[i]) begin bad++; $display("FAIL addu_ctl cyc=%0d got=%h want=%h", i, ctl, ec[i]); end
    end
    exp_ret = exp_ret + 32'd1;
    step(0, ADDU, 0, 0);
    total++; if (bus.retired !== exp_ret) begin bad++; $display("FAIL addu_ret got=%0d want=%0d", bus.retired, exp_ret); end
    total++; if (bus.state !== SF) begin bad++; $display("FAIL addu_end got=%0d want=0", bus.state); end
  endtask

  task automatic test_beq();
    logic [15:0] ec [3];
    for (int k = 0; k < 2; k++) begin
      ec = '{ce(1,0,0,0,0,0,0,0,0,0,0), 16'h0, ce(0,1,1-k,0,0,0,0,0,1,0,0)};
      for (int i = 0; i < 3; i++) begin
        step(i == 0 ? 1 : 0, BEQ, 1 - k, 0);
        total++; if (bus.state !== 3'(i)) begin bad++; $display("FAIL beq%0d_state cyc=%0d got=%0d want=%0d", k, i, bus.state, i); end
        total++; if (ctl !== ec[i]) begin bad++; $display("FAIL beq%0d_ctl cyc=%0d got=%h want=%h", k, i, ctl, ec[i]); end
      end
      exp_ret = exp_ret + 32'd1;
    end
    step(0, BEQ, 0, 0);
    total++; if (bus.retired !== exp_ret) begin bad++; $display("FAIL beq_ret got=%0d want=%0d", bus.retired, exp_ret); end
  endtask

  task automatic test_lw_wait();
    logic [2:0]  es [8];
    logic [15:0] ec [8];
    es = '{SF, SD, SE, SM, SM, SM, SM, SW};
    ec = '{ce(1,0,0,0,0,0,0,0,0,0,0), 16'h0, ce(0,0,0,0,0,0,1,1,0,0,0),
           ce(0,0,0,0,0,0,1,1,0,1,0), ce(0,0,0,0,0,0,1,1,0,1,0),
           ce(0,0,0,0,0,0,1,1,0,1,0), ce(0,0,0,0,0,0,1,1,0,1,0),
           ce(0,1,0,1,0,1,0,0,0,0,0)};
    for (int i = 0; i < 8; i++) begin
      step(i == 0 ? 1 : 0, LW, 0, i == 6 ? 1 : 0);
      total++; if (bus.state !== es[i]) begin bad++; $display("FAIL lw_state cyc=%0d got=%0d want=%0d", i, bus.state, es[i]); end
      total++; if (ctl !== ec[i]) begin bad++; $display("FAIL lw_ctl cyc=%0d got=%h want=%h", i, ctl, ec[i]); end
    end
    exp_ret = exp_ret + 32'd1;
    step(0, LW, 0, 0);
    total++; if (bus.retired !== exp_ret || bus.bus_err !== 1'b0) begin
      bad++; $display("FAIL lw_ret got=%0d/%b want=%0d/0", bus.retired, bus.bus_err, exp_ret); end
  endtask

  task automatic test_jal_jr();
    step(1, JAL, 0, 0);
    total++; if (ctl !== ce(1,0,0,0,0,0,0,0,0,0,0)) begin bad++; $display("FAIL jal_fetch got=%h", ctl); end
    step(0, JAL, 0, 0);
    total++; if (bus.state !== SD || ctl !== ce(0,1,2,1,2,2,0,0,0,0,0)) begin
      bad++; $display("FAIL jal_decode got=%0d/%h want=1/%h", bus.state, ctl, ce(0,1,2,1,2,2,0,0,0,0,0)); end
    step(1, JR, 0, 0);
    total++; if (bus.state !== SF || ctl !== ce(1,0,0,0,0,0,0,0,0,0,0)) begin
      bad++; $display("FAIL jr_fetch got=%0d/%h want=0/8000", bus.state, ctl); end
    step(0, JR, 0, 0);
    total++; if (bus.state !== SD || ctl !== ce(0,1,3,0,0,0,0,0,0,0,0)) begin
      bad++; $display("FAIL jr_decode got=%0d/%h want=1/%h", bus.state, ctl, ce(0,1,3,0,0,0,0,0,0,0,0)); end
    exp_ret = exp_ret + 32'd2;
    step(0, JR, 0, 0);
    total++; if (bus.retired !== exp_ret) begin bad++; $display("FAIL jaljr_ret got=%0d want=%0d", bus.retired, exp_ret); end
  endtask

  // sw waits 14 cycles; ready lands on the 15th MEM cycle (the would-be timeout) or never.
  task automatic test_sw(input int ready_at_limit);
    logic [2:0]  es;
    logic [15:0] ec;
    for (int i = 0; i < 18; i++) begin
      step(i == 0 ? 1 : 0, SW_I, 0, (i == 17 && ready_at_limit != 0) ? 1 : 0);
      es = (i < 3) ? 3'(i) : SM;
      ec = (i == 0) ? ce(1,0,0,0,0,0,0,0,0,0,0) :
           (i == 1) ? 16'h0 :
           (i == 2) ? ce(0,0,0,0,0,0,1,1,0,0,0) :
           (i == 17) ? ce(0,1,0,0,0,0,1,1,0,0,1) : ce(0,0,0,0,0,0,1,1,0,0,1);
      total++; if (bus.state !== es || ctl !== ec) begin
        bad++; $display("FAIL sw%0d cyc=%0d got=%0d/%h want=%0d/%h", ready_at_limit, i, bus.state, ctl, es, ec); end
    end
    total++; if (bus.bus_err !== 1'b0) begin bad++; $display("FAIL sw%0d_berr_early got=%b want=0", ready_at_limit, bus.bus_err); end
    exp_ret = exp_ret + 32'd1;
    step(0, SW_I, 0, 0);
    total++; if (bus.state !== SF || bus.retired !== exp_ret) begin
      bad++; $display("FAIL sw%0d_end got=%0d/%0d want=0/%0d", ready_at_limit, bus.state, bus.retired, exp_ret); end
    total++; if (bus.bus_err !== 1'(ready_at_limit == 0)) begin
      bad++; $display("FAIL sw%0d_berr got=%b want=%b", ready_at_limit, bus.bus_err, ready_at_limit == 0); end
  endtask

  task automatic test_illegal_sticky();
    step(1, BAD, 0, 0);
    step(0, BAD, 0, 0);
    total++; if (bus.state !== SD || ctl !== ce(0,1,0,0,0,0,0,0,0,0,0) || bus.illegal !== 1'b0) begin
      bad++; $display("FAIL ill_decode got=%0d/%h/%b want=1/4000/0", bus.state, ctl, bus.illegal); end
    exp_ret = exp_ret + 32'd1;
    step(0, BAD, 0, 0);
    total++; if (bus.illegal !== 1'b1 || bus.state !== SF || bus.retired !== exp_ret) begin
      bad++; $display("FAIL ill_set got=%b/%0d/%0d want=1/0/%0d", bus.illegal, bus.state, bus.retired, exp_ret); end
    step(1, ADDU, 0, 0); step(0, ADDU, 0, 0); step(0, ADDU, 0, 0); step(0, ADDU, 0, 0);
    step(0, ADDU, 0, 0);
    total++; if ({bus.illegal, bus.bus_err} !== 2'b11) begin
      bad++; $display("FAIL flags_sticky got=%b%b want=11", bus.illegal, bus.bus_err); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    #1;
    total++; if ({bus.illegal, bus.bus_err} !== 2'b00 || bus.retired !== 32'd0) begin
      bad++; $display("FAIL flags_clear got=%b%b/%0d want=00/0", bus.illegal, bus.bus_err, bus.retired); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_addu();
    test_beq();
    test_lw_wait();
    test_jal_jr();
    test_sw(1);
    test_sw(0);
    test_illegal_sticky();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
